// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage
//
// Execute stage plus the EX/MEM pipeline register.
//   * Resolves operands with MEM->EX and WB->EX forwarding (MEM has priority).
//   * Single-cycle ALU for logic, shift, compare, add/sub, multiply and PASSB.
//   * Radix-2 restoring divider for DIV/DIVU/REM/REMU. It runs IDLE->BUSY->DONE
//     and holds ex_stall_req high for 33 cycles. While stalled, the EX/MEM
//     register loads bubbles.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   *_from_idex               ID/EX register contents for the current op
//   wb_rd/wb_write_reg/wb_data  WB-stage write port, used for forwarding
//   *_to_mem                  registered EX/MEM outputs
//   ex_stall_req              combinational; 1 = freeze IF/ID and ID/EX
// ---------------------------------------------------------------------------
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_addr_from_idex,
  input  logic [4:0]      rs1_from_idex,
  input  logic [4:0]      rs2_from_idex,
  input  logic [4:0]      rd_from_idex,
  input  logic [5:0]      alu_op_from_idex,
  input  logic            use_imm_from_idex,
  input  logic            write_reg_from_idex,
  input  logic            read_mem_from_idex,
  input  logic            write_mem_from_idex,
  input  logic [XLEN-1:0] imm_from_idex,
  input  logic [XLEN-1:0] reg_data1_from_idex,
  input  logic [XLEN-1:0] reg_data2_from_idex,
  input  logic [4:0]      wb_rd,
  input  logic            wb_write_reg,
  input  logic [XLEN-1:0] wb_data,
  output logic [31:0]     inst_addr_to_mem,
  output logic [4:0]      rd_to_mem,
  output logic            write_reg_to_mem,
  output logic            read_mem_to_mem,
  output logic            write_mem_to_mem,
  output logic [XLEN-1:0] alu_result_to_mem,
  output logic [XLEN-1:0] store_data_to_mem,
  output logic            ex_stall_req
);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_SLL   = 6'h05;
  localparam logic [5:0] OP_SRL   = 6'h06;
  localparam logic [5:0] OP_SRA   = 6'h07;
  localparam logic [5:0] OP_SLT   = 6'h08;
  localparam logic [5:0] OP_SLTU  = 6'h09;
  localparam logic [5:0] OP_PASSB = 6'h0A;
  localparam logic [5:0] OP_MUL   = 6'h10;

  localparam int SHW  = $clog2(XLEN);
  localparam int CNTW = $clog2(DIV_ITERS + 1);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  div_state_t      div_state;
  logic [CNTW-1:0] div_cnt;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] div_dsr;
  logic            div_q_neg;
  logic            div_r_neg;
  logic            div_zero;
  logic            div_want_rem;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;

  logic            is_div;
  logic            div_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] div_q_fix;
  logic [XLEN-1:0] div_r_fix;
  logic [XLEN-1:0] div_result;

  // Operand forwarding. A load in MEM does not yet have its data, so it is
  // never a forwarding source; ID already inserts the load-use bubble.
  always_comb begin
    fwd_a = reg_data1_from_idex;
    if (write_reg_to_mem && !read_mem_to_mem && rd_to_mem != 5'd0 &&
        rd_to_mem == rs1_from_idex)
      fwd_a = alu_result_to_mem;
    else if (wb_write_reg && wb_rd != 5'd0 && wb_rd == rs1_from_idex)
      fwd_a = wb_data;
  end

  always_comb begin
    fwd_b = reg_data2_from_idex;
    if (write_reg_to_mem && !read_mem_to_mem && rd_to_mem != 5'd0 &&
        rd_to_mem == rs2_from_idex)
      fwd_b = alu_result_to_mem;
    else if (wb_write_reg && wb_rd != 5'd0 && wb_rd == rs2_from_idex)
      fwd_b = wb_data;
  end

  assign op_b = use_imm_from_idex ? imm_from_idex : fwd_b;

  // Divide opcodes are 0x14..0x17. Bit 0 clear selects signed, bit 1 set
  // selects remainder.
  assign is_div     = (alu_op_from_idex[5:2] == 4'b0101);
  assign div_signed = ~alu_op_from_idex[0];
  assign a_neg      = div_signed & fwd_a[XLEN-1];
  assign b_neg      = div_signed & op_b[XLEN-1];
  assign abs_a      = a_neg ? -fwd_a : fwd_a;
  assign abs_b      = b_neg ? -op_b : op_b;

  // Single-cycle ALU. Divide codes land in the default because their result
  // comes from the divider in DONE.
  always_comb begin
    alu_res = '0;
    shamt   = op_b[SHW-1:0];
    case (alu_op_from_idex)
      OP_ADD:   alu_res = fwd_a + op_b;
      OP_SUB:   alu_res = fwd_a - op_b;
      OP_AND:   alu_res = fwd_a & op_b;
      OP_OR:    alu_res = fwd_a | op_b;
      OP_XOR:   alu_res = fwd_a ^ op_b;
      OP_SLL:   alu_res = fwd_a << shamt;
      OP_SRL:   alu_res = fwd_a >> shamt;
      OP_SRA:   alu_res = $signed(fwd_a) >>> shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
      OP_PASSB: alu_res = op_b;
      OP_MUL:   alu_res = fwd_a * op_b;
      default:  alu_res = '0;
    endcase
  end

  // One restoring step. The remainder always stays below the divisor, so the
  // top bit of the difference is a clean borrow flag. With a zero divisor every
  // step succeeds: the quotient becomes all ones and the remainder becomes the
  // dividend.
  assign div_shift = {div_rem, div_quo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, div_dsr};

  // Sign correction. The remainder takes the dividend's sign, so a signed
  // divide by zero yields the original dividend after correction. Only the
  // quotient needs the explicit all-ones override.
  assign div_q_fix  = div_q_neg ? -div_quo : div_quo;
  assign div_r_fix  = div_r_neg ? -div_rem : div_rem;
  assign div_result = div_want_rem ? div_r_fix : (div_zero ? '1 : div_q_fix);

  // Stall covers the start cycle and all BUSY cycles. It is gated by reset so
  // that an aborted divide releases the pipeline at once.
  assign ex_stall_req = rst & (((div_state == DIV_IDLE) & is_div) |
                               (div_state == DIV_BUSY));

  // Divider control. The start cycle latches magnitudes and signs. BUSY runs
  // DIV_ITERS steps. DONE lasts one cycle while the result is registered, and
  // the FSM then always returns to IDLE, so the held divide is never restarted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_state    <= DIV_IDLE;
      div_cnt      <= '0;
      div_quo      <= '0;
      div_rem      <= '0;
      div_dsr      <= '0;
      div_q_neg    <= 1'b0;
      div_r_neg    <= 1'b0;
      div_zero     <= 1'b0;
      div_want_rem <= 1'b0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (is_div) begin
            div_quo      <= abs_a;
            div_rem      <= '0;
            div_dsr      <= abs_b;
            div_q_neg    <= a_neg ^ b_neg;
            div_r_neg    <= a_neg;
            div_zero     <= (op_b == '0);
            div_want_rem <= alu_op_from_idex[1];
            div_cnt      <= '0;
            div_state    <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (!div_diff[XLEN]) begin
            div_rem <= div_diff[XLEN-1:0];
            div_quo <= {div_quo[XLEN-2:0], 1'b1};
          end else begin
            div_rem <= div_shift[XLEN-1:0];
            div_quo <= {div_quo[XLEN-2:0], 1'b0};
          end
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == CNTW'(DIV_ITERS - 1))
            div_state <= DIV_DONE;
        end
        DIV_DONE: begin
          div_state <= DIV_IDLE;
        end
        default: begin
          div_state <= DIV_IDLE;
        end
      endcase
    end
  end

  // EX/MEM register. It loads a bubble while stalled, the divider result in
  // DONE, and the ALU result otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_addr_to_mem  <= '0;
      rd_to_mem         <= '0;
      write_reg_to_mem  <= 1'b0;
      read_mem_to_mem   <= 1'b0;
      write_mem_to_mem  <= 1'b0;
      alu_result_to_mem <= '0;
      store_data_to_mem <= '0;
    end else if (ex_stall_req) begin
      inst_addr_to_mem  <= '0;
      rd_to_mem         <= '0;
      write_reg_to_mem  <= 1'b0;
      read_mem_to_mem   <= 1'b0;
      write_mem_to_mem  <= 1'b0;
      alu_result_to_mem <= '0;
      store_data_to_mem <= '0;
    end else begin
      inst_addr_to_mem  <= inst_addr_from_idex;
      rd_to_mem         <= rd_from_idex;
      write_reg_to_mem  <= write_reg_from_idex;
      read_mem_to_mem   <= read_mem_from_idex;
      write_mem_to_mem  <= write_mem_from_idex;
      alu_result_to_mem <= (div_state == DIV_DONE) ? div_result : alu_res;
      store_data_to_mem <= fwd_b;
    end
  end

endmodule
